cic_decim_ctrl: RTL and testbench
=================================

Name: cic_decim_ctrl

Overview:
Sequencing controller for the 3rd-order CIC decimator (integrator → decimated comb). It gates the integrator enable and generates the comb-stage enable once every R accepted input samples, with R a runtime-programmable ratio. It discards the first ORDER comb outputs after start or reconfiguration. It presents the comb result on a one-entry valid/ready output register with sticky overrun detection. It replaces the free-running clock divider as the decimation timing source.

Parameters:
DATA_W, 51, width of comb result and output data
RATIO_W, 16, width of decimation ratio
DEF_RATIO, 64, ratio loaded at reset
ORDER, 3, comb outputs discarded while priming
COMB_LAT, 1, cycles from comb_en to comb_data valid (≥1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
run_en  in  1  level; 1 = decimator running
in_valid  in  1  input sample strobe (clock enable of the integrator chain)
ratio_in  in  RATIO_W  new decimation ratio
ratio_load  in  1  one-cycle pulse; latch ratio_in
integ_en  out  1  integrator enable
comb_en  out  1  one-cycle comb enable pulse
comb_data  in  DATA_W  comb stage result
out_data  out  DATA_W  held decimated sample
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
overrun  out  1  sticky: a result was dropped
primed  out  1  state == RUN
ratio_cur  out  RATIO_W  active ratio

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE, ratio_cur=DEF_RATIO, phase=0, prime_cnt=0, delay line cleared, comb_en=0, out_valid=0, out_data=0, overrun=0.
- integ_en = in_valid & (state != IDLE). Combinational, same cycle.
- Ratio latch: ratio_load=1 → ratio_cur = max(ratio_in, 2) on the next edge. Effective in every state.
- Phase counter (PRIME/RUN only):
  - Counts cycles with in_valid=1, range 0..ratio_cur-1.
  - When in_valid=1 and phase==ratio_cur-1: phase→0 and comb_en=1 on the next cycle (registered, exactly one cycle wide).
- Capture event: comb_en delayed COMB_LAT cycles through a shift register.
- FSM:
  - IDLE: run_en=1 → PRIME.
  - PRIME: each capture event increments prime_cnt. A capture event with prime_cnt==ORDER-1 → RUN. All PRIME captures are discarded.
  - RUN: capture events load the output register.
  - run_en=0 in any state → IDLE next edge. phase, prime_cnt, delay line, out_valid and overrun are cleared.
  - ratio_load=1 while in PRIME or RUN (with run_en=1) → PRIME. phase=0, prime_cnt=0, delay line flushed. A comb_en that would have been generated that cycle is suppressed. out_valid and out_data are retained.
- Output register (RUN):
  - Capture while out_valid=0, or while out_valid=1 & out_ready=1: out_data←comb_data, out_valid=1.
  - Capture while out_valid=1 & out_ready=0: data dropped, out_data unchanged, overrun←1.
  - No capture and out_ready=1: out_valid←0.
- Simultaneous events:
  - run_en=0 together with ratio_load: IDLE wins; the ratio is still latched.
  - in_valid in the ratio_load cycle is not counted.
- overrun clears only on reset or IDLE entry.
- Latency: comb_en is 1 cycle after the R-th in_valid. out_valid rises COMB_LAT+1 cycles after comb_en.

Decomposition:
- Package cic_ctrl_pkg: state enum (IDLE, PRIME, RUN), MIN_RATIO=2, ORDER default.
- Sub-module cic_strobe_delay: COMB_LAT-deep, 1-bit shift register with synchronous flush.
- Everything else lives in cic_decim_ctrl.

Test Plan:
- Reset; run_en=1; in_valid every cycle, R=64 → comb_en pulses every 64 cycles; out_valid first rises at the 4th comb_en + COMB_LAT + 1; primed=1 from that capture on.
- R=4, in_valid on alternate cycles → comb_en every 8 cycles; integ_en mirrors in_valid; captured out_data equals comb_data at each capture cycle.
- ratio_load with ratio_in=1, then ratio_in=0 → ratio_cur=2 in both cases; comb_en every 2nd input; re-priming discards 3 outputs after each load.
- R=4, out_ready=0 held → first RUN capture sets out_valid; second capture sets overrun=1 and out_data keeps the first value; out_ready=1 then drains; overrun stays 1 until run_en=0.
- Mid-run, ratio_load (R=8) in the same cycle as the 4th in_valid → no comb_en that cycle; phase restarts; next comb_en after 8 inputs; pending out_valid retained.
- run_en=0 coincident with ratio_load → IDLE, out_valid=0, integ_en=0, ratio_cur updated; reset asserted mid-RUN → all outputs zero, ratio_cur=64.

Source files
------------

// File: rtl/cic_ctrl_pkg.sv
// Shared types and constants for the CIC decimator sequencing controller.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int MIN_RATIO = 2;
    localparam int ORDER_DEF = 3;

endpackage

// File: rtl/cic_strobe_delay.sv
// Fixed-depth 1-bit strobe delay line with synchronous flush.
module cic_strobe_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic strobe,
    output logic delayed
);

    logic [DEPTH-1:0] taps;

    // The cast drops the oldest tap, which also covers DEPTH == 1.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            taps <= '0;
        end else begin
            taps <= DEPTH'({taps, strobe});
        end
    end

    assign delayed = taps[DEPTH-1];

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencing: integrator gating, decimation strobe, comb priming
// and a one-entry valid/ready output register with sticky overrun.
module cic_decim_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int DATA_W    = 51,
    parameter int RATIO_W   = 16,
    parameter int DEF_RATIO = 64,
    parameter int ORDER     = ORDER_DEF,
    parameter int COMB_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_en,
    input  logic               in_valid,
    input  logic [RATIO_W-1:0] ratio_in,
    input  logic               ratio_load,
    output logic               integ_en,
    output logic               comb_en,
    input  logic [DATA_W-1:0]  comb_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overrun,
    output logic               primed,
    output logic [RATIO_W-1:0] ratio_cur
);

    localparam int                 PRIME_W   = $clog2(ORDER + 1);
    localparam logic [RATIO_W-1:0] MIN_R     = RATIO_W'(MIN_RATIO);
    localparam logic [RATIO_W-1:0] RESET_R   = RATIO_W'(DEF_RATIO);
    localparam logic [PRIME_W-1:0] PRIME_END = PRIME_W'(ORDER - 1);

    state_t             state;
    logic [RATIO_W-1:0] phase;
    logic [PRIME_W-1:0] prime_cnt;
    logic               capture;
    logic               reprime;
    logic               flush;

    assign integ_en = in_valid & (state != IDLE);
    assign reprime  = ratio_load & (state != IDLE);
    assign flush    = !run_en | reprime;

    cic_strobe_delay #(
        .DEPTH (COMB_LAT)
    ) u_strobe_delay (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .strobe  (comb_en),
        .delayed (capture)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ratio_cur <= RESET_R;
            phase     <= '0;
            prime_cnt <= '0;
            comb_en   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
            primed    <= 1'b0;
        end else begin
            if (ratio_load) begin
                ratio_cur <= (ratio_in < MIN_R) ? MIN_R : ratio_in;
            end
            comb_en <= 1'b0;

            if (!run_en) begin
                state     <= IDLE;
                primed    <= 1'b0;
                phase     <= '0;
                prime_cnt <= '0;
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end else if (reprime) begin
                // Output register is left untouched so a pending sample survives.
                state     <= PRIME;
                primed    <= 1'b0;
                phase     <= '0;
                prime_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= PRIME;
                    end
                    PRIME, RUN: begin
                        if (in_valid) begin
                            if (phase == ratio_cur - RATIO_W'(1)) begin
                                phase   <= '0;
                                comb_en <= 1'b1;
                            end else begin
                                phase <= phase + RATIO_W'(1);
                            end
                        end

                        if (state == PRIME) begin
                            if (capture) begin
                                prime_cnt <= prime_cnt + PRIME_W'(1);
                                if (prime_cnt == PRIME_END) begin
                                    state  <= RUN;
                                    primed <= 1'b1;
                                end
                            end
                        end else if (capture) begin
                            if (!out_valid || out_ready) begin
                                out_data  <= comb_data;
                                out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl against a queue-based behavioural model.
module tb_cic_decim_ctrl;

    localparam int DATA_W    = 51;
    localparam int RATIO_W   = 16;
    localparam int DEF_RATIO = 64;
    localparam int ORDER     = 3;
    localparam int COMB_LAT  = 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               run_en;
    logic               in_valid;
    logic [RATIO_W-1:0] ratio_in;
    logic               ratio_load;
    logic               integ_en;
    logic               comb_en;
    logic [DATA_W-1:0]  comb_data;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               overrun;
    logic               primed;
    logic [RATIO_W-1:0] ratio_cur;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cic_decim_ctrl #(
        .DATA_W    (DATA_W),
        .RATIO_W   (RATIO_W),
        .DEF_RATIO (DEF_RATIO),
        .ORDER     (ORDER),
        .COMB_LAT  (COMB_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_en     (run_en),
        .in_valid   (in_valid),
        .ratio_in   (ratio_in),
        .ratio_load (ratio_load),
        .integ_en   (integ_en),
        .comb_en    (comb_en),
        .comb_data  (comb_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .primed     (primed),
        .ratio_cur  (ratio_cur)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Comb data changes away from the sampling edge.
    always @(negedge clk) comb_data <= DATA_W'({$urandom, $urandom});

    // Model: inputs since restart, discards remaining, and a queue of cycles at
    // which a comb result becomes capturable.
    bit              m_run = 0;
    int              m_cnt = 0;
    int              m_left = ORDER;
    int              m_ratio = DEF_RATIO;
    int              m_next_ratio;
    bit              m_comb = 0;
    bit              m_val = 0;
    bit              m_ov = 0;
    logic [DATA_W-1:0] m_data = '0;
    int              cap_q[$];
    int              cyc = 0;
    bit              cap_now;

    always @(posedge clk) begin
        cap_now = 0;
        if (cap_q.size() > 0 && cap_q[0] == cyc) begin
            cap_now = 1;
            void'(cap_q.pop_front());
        end
        if (!reset) begin
            m_run = 0; m_cnt = 0; m_left = ORDER; cap_q.delete(); m_comb = 0;
            m_val = 0; m_ov = 0; m_data = '0; m_ratio = DEF_RATIO;
        end else begin
            m_next_ratio = ratio_load ? ((ratio_in < 16'd2) ? 2 : int'(ratio_in)) : m_ratio;
            m_comb = 0;
            if (!run_en) begin
                m_run = 0; m_cnt = 0; m_left = ORDER; cap_q.delete(); m_val = 0; m_ov = 0;
            end else if (!m_run) begin
                m_run = 1; m_cnt = 0; m_left = ORDER;
            end else if (ratio_load) begin
                m_cnt = 0; m_left = ORDER; cap_q.delete();
            end else begin
                if (in_valid) begin
                    m_cnt++;
                    if (m_cnt == m_ratio) begin
                        m_cnt = 0;
                        m_comb = 1;
                        cap_q.push_back(cyc + 1 + COMB_LAT);
                    end
                end
                if (cap_now) begin
                    if (m_left > 0) m_left--;
                    else if (!m_val || out_ready) begin m_data = comb_data; m_val = 1; end
                    else m_ov = 1;
                end else if (m_left == 0 && out_ready) begin
                    m_val = 0;
                end
            end
            m_ratio = m_next_ratio;
        end
        cyc++;
    end

    // Per-cycle compare plus rise-time logs for the literal timing checks.
    bit chk_en = 0;
    int ncyc = 0;
    bit p_comb = 0, p_ov = 0, p_pr = 0;
    int comb_t[$], ov_t[$], pr_t[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("integ_en", integ_en, in_valid & m_run);
            check("comb_en", comb_en, m_comb);
            check("out_valid", out_valid, m_val);
            check("out_data", out_data, m_data);
            check("overrun", overrun, m_ov);
            check("primed", primed, m_run && m_left == 0);
            check("ratio_cur", ratio_cur, m_ratio);
            if (comb_en && !p_comb) comb_t.push_back(ncyc);
            if (out_valid && !p_ov) ov_t.push_back(ncyc);
            if (primed && !p_pr) pr_t.push_back(ncyc);
        end
        p_comb = comb_en; p_ov = out_valid; p_pr = primed;
        ncyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        comb_t.delete(); ov_t.delete(); pr_t.delete();
    endtask

    task automatic load_ratio(input logic [RATIO_W-1:0] r);
        for (int i = 0; i < 200 && out_valid; i++) tick();
        ratio_in = r; ratio_load = 1'b1;
        tick();
        ratio_load = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b0; run_en = 1'b0; in_valid = 1'b0; ratio_in = '0;
        ratio_load = 1'b0; out_ready = 1'b0;
        tick();
        chk_en = 1;
        tick();
        check("rst_ratio", ratio_cur, 64);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_comb_en", comb_en, 0);
        reset = 1'b1;

        // R=64, input every cycle
        run_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        clear_logs();
        for (int i = 0; i < 420; i++) tick();
        check("t1_comb_period", (comb_t.size() > 1) ? 64'(comb_t[1] - comb_t[0]) : '1, 64);
        check("t1_primed_rise", (pr_t.size() > 0 && comb_t.size() > 0) ? 64'(pr_t[0] - comb_t[0]) : '1, 130);
        check("t1_first_valid", (ov_t.size() > 0 && comb_t.size() > 0) ? 64'(ov_t[0] - comb_t[0]) : '1, 194);

        // R=4, input on alternate cycles
        in_valid = 1'b0;
        load_ratio(16'd4);
        clear_logs();
        for (int i = 0; i < 80; i++) begin
            in_valid = (i % 2 == 0);
            tick();
        end
        check("t2_comb_period_a", (comb_t.size() > 2) ? 64'(comb_t[1] - comb_t[0]) : '1, 8);
        check("t2_comb_period_b", (comb_t.size() > 2) ? 64'(comb_t[2] - comb_t[1]) : '1, 8);
        check("t2_first_valid", (ov_t.size() > 0 && comb_t.size() > 0) ? 64'(ov_t[0] - comb_t[0]) : '1, 26);

        // Ratio clamp to 2 for ratio_in of 1 and 0
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            load_ratio((k == 0) ? 16'd1 : 16'd0);
            check("t3_clamp", ratio_cur, 2);
            clear_logs();
            for (int i = 0; i < 30; i++) tick();
            check("t3_comb_period", (comb_t.size() > 1) ? 64'(comb_t[1] - comb_t[0]) : '1, 2);
            check("t3_first_valid", (ov_t.size() > 0 && comb_t.size() > 0) ? 64'(ov_t[0] - comb_t[0]) : '1, 8);
        end

        // Stop coincident with ratio load: IDLE wins, ratio still latched
        run_en = 1'b0; ratio_in = 16'd4; ratio_load = 1'b1;
        tick();
        ratio_load = 1'b0;
        check("t6_idle_valid", out_valid, 0);
        check("t6_idle_integ", integ_en, 0);
        check("t6_idle_ratio", ratio_cur, 4);
        check("t6_idle_primed", primed, 0);

        // Overrun with out_ready held low
        run_en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 100 && !primed; i++) tick();
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("t4_valid_set", out_valid, 1);
        check("t4_no_overrun_yet", overrun, 0);
        for (int i = 0; i < 20 && !overrun; i++) tick();
        check("t4_overrun_set", overrun, 1);
        check("t4_valid_held", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("t4_overrun_sticky", overrun, 1);
        out_ready = 1'b0; run_en = 1'b0;
        tick();
        check("t4_overrun_clear", overrun, 0);
        check("t4_valid_clear", out_valid, 0);

        // Reload to R=8 on the 4th input of a group, with a pending sample
        run_en = 1'b1;
        for (int i = 0; i < 100 && !primed; i++) tick();
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        for (int i = 0; i < 20 && !comb_en; i++) tick();
        check("t5_sync", comb_en, 1);
        tick(); tick(); tick();
        ratio_in = 16'd8; ratio_load = 1'b1;
        tick();
        ratio_load = 1'b0;
        check("t5_suppressed", comb_en, 0);
        check("t5_valid_kept", out_valid, 1);
        check("t5_ratio", ratio_cur, 8);
        n = 0;
        while (!comb_en && n < 40) begin tick(); n++; end
        check("t5_next_comb", n, 8);

        // Reset mid-RUN
        out_ready = 1'b1;
        load_ratio(16'd2);
        for (int i = 0; i < 30; i++) tick();
        check("t7_running", primed, 1);
        reset = 1'b0;
        tick();
        check("t7_rst_data", out_data, 0);
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_ratio", ratio_cur, 64);
        check("t7_rst_integ", integ_en, 0);
        check("t7_rst_primed", primed, 0);
        reset = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
